// File: rtl/multi_channel_counter.sv
// multi_channel_counter: N independent up/down counters with load, a programmable
// terminal value, per-channel wrap/saturate mode, event pulses and sticky status.
module multi_channel_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [CHANNELS-1:0]         en,
  input  logic [CHANNELS-1:0]         dir_up,
  input  logic [CHANNELS-1:0]         sat_mode,
  input  logic [CHANNELS-1:0]         load,
  input  logic [CHANNELS*WIDTH-1:0]   load_val,
  input  logic [CHANNELS*WIDTH-1:0]   limit,
  input  logic [CHANNELS-1:0]         clr_sticky,
  output logic [CHANNELS*WIDTH-1:0]   count,
  output logic [CHANNELS-1:0]         ovf,
  output logic [CHANNELS-1:0]         unf,
  output logic [CHANNELS-1:0]         ovf_sticky,
  output logic [CHANNELS-1:0]         unf_sticky,
  output logic [CHANNELS-1:0]         at_limit
);

  localparam int unsigned CW = CHANNELS * WIDTH;

  logic [CW-1:0]       cnt_d;
  logic [CHANNELS-1:0] ovf_d;
  logic [CHANNELS-1:0] unf_d;

  // Per-channel next count and boundary events: load > enabled step > hold.
  always_comb begin
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] lv;
    cnt_d = count;
    ovf_d = '0;
    unf_d = '0;
    cur   = '0;
    lim   = '0;
    lv    = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cur = count[i*WIDTH +: WIDTH];
      lim = limit[i*WIDTH +: WIDTH];
      lv  = load_val[i*WIDTH +: WIDTH];
      if (load[i]) begin
        cnt_d[i*WIDTH +: WIDTH] = (lv > lim) ? lim : lv;
      end else if (en[i]) begin
        if (dir_up[i]) begin
          if (cur < lim) begin
            cnt_d[i*WIDTH +: WIDTH] = cur + WIDTH'(1);
          end else begin
            // At or above the bound (limit may have been lowered under us).
            ovf_d[i] = 1'b1;
            cnt_d[i*WIDTH +: WIDTH] = sat_mode[i] ? lim : '0;
          end
        end else begin
          if (cur > lim) begin
            // Re-clamp into range after a limit decrease; not an event.
            cnt_d[i*WIDTH +: WIDTH] = lim;
          end else if (cur != '0) begin
            cnt_d[i*WIDTH +: WIDTH] = cur - WIDTH'(1);
          end else begin
            unf_d[i] = 1'b1;
            cnt_d[i*WIDTH +: WIDTH] = sat_mode[i] ? '0 : lim;
          end
        end
      end
    end
  end

  // Terminal-value compare straight from the registered count and live limit.
  always_comb begin
    at_limit = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      at_limit[i] = (count[i*WIDTH +: WIDTH] >= limit[i*WIDTH +: WIDTH]);
    end
  end

  // State registers; a simultaneous event beats the sticky clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count      <= '0;
      ovf        <= '0;
      unf        <= '0;
      ovf_sticky <= '0;
      unf_sticky <= '0;
    end else begin
      count      <= cnt_d;
      ovf        <= ovf_d;
      unf        <= unf_d;
      ovf_sticky <= (ovf_sticky & ~clr_sticky) | ovf_d;
      unf_sticky <= (unf_sticky & ~clr_sticky) | unf_d;
    end
  end

endmodule

// File: tb/tb_multi_channel_counter.sv
// Directed bench for multi_channel_counter, WIDTH=4, CHANNELS=2.
module tb_multi_channel_counter;

  localparam int unsigned W = 4;
  localparam int unsigned C = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [C-1:0]   en, dir_up, sat_mode, load, clr_sticky;
  logic [C*W-1:0] load_val, limit;
  logic [C*W-1:0] count;
  logic [C-1:0]   ovf, unf, ovf_sticky, unf_sticky, at_limit;

  int n_cmp = 0;
  int n_err = 0;

  multi_channel_counter #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .dir_up(dir_up), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .limit(limit), .clr_sticky(clr_sticky),
    .count(count), .ovf(ovf), .unf(unf), .ovf_sticky(ovf_sticky),
    .unf_sticky(unf_sticky), .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_up[8]  = '{1, 2, 3, 4, 5, 0, 1, 2};
  int exp_dn[4]  = '{1, 0, 0, 0};
  int exp_unf[4] = '{0, 0, 1, 1};

  initial begin
    // Reset with arbitrary inputs applied.
    reset_n    = 1'b0;
    en         = C'($urandom);
    dir_up     = C'($urandom);
    sat_mode   = C'($urandom);
    load       = C'($urandom);
    clr_sticky = C'($urandom);
    load_val   = (C*W)'($urandom);
    limit      = (C*W)'($urandom);
    step();
    step();
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    chk("rst_ovf_sticky", ovf_sticky, 0);
    chk("rst_unf_sticky", unf_sticky, 0);

    reset_n = 1'b1;
    en = '0; dir_up = '0; sat_mode = '0; load = '0; clr_sticky = '0;
    load_val = '0;
    limit = {4'd9, 4'd5};

    // ch0 wrap up, limit 5.
    en[0] = 1'b1; dir_up[0] = 1'b1; sat_mode[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("wrap_cnt%0d", k), count[3:0], exp_up[k]);
      chk($sformatf("wrap_ovf%0d", k), ovf[0], (k == 5) ? 1 : 0);
      chk($sformatf("wrap_stk%0d", k), ovf_sticky[0], (k >= 5) ? 1 : 0);
      if (k == 4) chk("wrap_at_limit", at_limit[0], 1);
    end
    en[0] = 1'b0;
    clr_sticky[0] = 1'b1;
    step();
    chk("clr_stk", ovf_sticky[0], 0);
    chk("hold_cnt", count[3:0], 2);
    clr_sticky[0] = 1'b0;

    // ch1 saturate down from 2, limit 9.
    load[1] = 1'b1; load_val[7:4] = 4'd2;
    step();
    chk("sd_load", count[7:4], 2);
    load[1] = 1'b0;
    en[1] = 1'b1; dir_up[1] = 1'b0; sat_mode[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("sd_cnt%0d", k), count[7:4], exp_dn[k]);
      chk($sformatf("sd_unf%0d", k), unf[1], exp_unf[k]);
      chk($sformatf("sd_stk%0d", k), unf_sticky[1], exp_unf[k]);
    end
    chk("sd_ch0_untouched", count[3:0], 2);
    en[1] = 1'b0;

    // Load beats enable and is clamped to limit.
    limit[3:0] = 4'd7; load[0] = 1'b1; en[0] = 1'b1; dir_up[0] = 1'b1;
    load_val[3:0] = 4'd12;
    step();
    chk("ld_clamp", count[3:0], 7);
    chk("ld_ovf", ovf[0], 0);
    chk("ld_unf", unf[0], 0);
    load[0] = 1'b0;
    step();
    chk("ld_wrap", count[3:0], 0);
    chk("ld_wrap_ovf", ovf[0], 1);

    // Limit lowered below the count: up wraps with event.
    en[0] = 1'b0; limit[3:0] = 4'd15; load[0] = 1'b1; load_val[3:0] = 4'd10;
    step();
    chk("lc_load", count[3:0], 10);
    load[0] = 1'b0; limit[3:0] = 4'd4;
    #1;
    chk("lc_at_limit_hi", at_limit[0], 1);
    en[0] = 1'b1; dir_up[0] = 1'b1;
    step();
    chk("lc_up_cnt", count[3:0], 0);
    chk("lc_up_ovf", ovf[0], 1);
    chk("lc_at_limit_lo", at_limit[0], 0);
    // Same, counting down: re-clamp without event.
    en[0] = 1'b0; limit[3:0] = 4'd15; load[0] = 1'b1;
    step();
    load[0] = 1'b0; limit[3:0] = 4'd4; en[0] = 1'b1; dir_up[0] = 1'b0;
    step();
    chk("lc_dn_cnt", count[3:0], 4);
    chk("lc_dn_ovf", ovf[0], 0);
    chk("lc_dn_unf", unf[0], 0);
    chk("lc_dn_at_limit", at_limit[0], 1);
    step();
    chk("lc_dn_cnt2", count[3:0], 3);
    chk("lc_dn_at_limit2", at_limit[0], 0);
    en[0] = 1'b0;

    // Saturate up held at the bound pulses every cycle.
    limit[3:0] = 4'd3; load[0] = 1'b1; load_val[3:0] = 4'd3; sat_mode[0] = 1'b1;
    step();
    load[0] = 1'b0; en[0] = 1'b1; dir_up[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("su_cnt%0d", k), count[3:0], 3);
      chk($sformatf("su_ovf%0d", k), ovf[0], 1);
    end
    en[0] = 1'b0;

    // Sticky race on ch1: event and clear together, set wins.
    limit[7:4] = 4'd0; en[1] = 1'b1; dir_up[1] = 1'b1; sat_mode[1] = 1'b1;
    clr_sticky[1] = 1'b1;
    step();
    chk("race_ovf", ovf[1], 1);
    chk("race_ovf_stk", ovf_sticky[1], 1);
    chk("race_unf_stk", unf_sticky[1], 0);
    chk("race_cnt", count[7:4], 0);
    en[1] = 1'b0;
    step();
    chk("race_clr_stk", ovf_sticky[1], 0);
    chk("race_clr_ovf", ovf[1], 0);
    clr_sticky[1] = 1'b0;

    // Reset in the middle of activity discards state, no events.
    limit = {4'd0, 4'd9}; en = 2'b11; dir_up = 2'b11; sat_mode = 2'b00;
    step();
    reset_n = 1'b0;
    step();
    chk("mid_rst_cnt", count, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_stk", ovf_sticky, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_channel_counter.md
# multi_channel_counter

Parametrised N-channel up/down counter; successor to the single-channel free-running counter. Each channel has its own enable, direction, synchronous load, programmable terminal value (modulo limit) and per-channel wrap or saturate mode, plus registered overflow/underflow event pulses and sticky status bits. It sits in timer/event-counting subsystems where several independent counters share one clock domain and need software-visible status.

## Interface
- `WIDTH`, 8, counter width per channel (≥2)
- `CHANNELS`, 4, number of independent counters (≥1)
- `clk`  in  1  clock, all logic on rising edge
- `reset_n`  in  1  reset, synchronous and active-low
- `en`  in  CHANNELS  per-channel count enable
- `dir_up`  in  CHANNELS  1 = count up, 0 = count down
- `sat_mode`  in  CHANNELS  1 = saturate at bound, 0 = wrap
- `load`  in  CHANNELS  synchronous load strobe
- `load_val`  in  CHANNELS*WIDTH  load value, channel i at `[i*WIDTH +: WIDTH]`
- `limit`  in  CHANNELS*WIDTH  terminal value per channel; range is 0..limit
- `clr_sticky`  in  CHANNELS  clears sticky status bits
- `count`  out  CHANNELS*WIDTH  registered counter values
- `ovf`  out  CHANNELS  registered 1-cycle pulse: up-count hit upper bound
- `unf`  out  CHANNELS  registered 1-cycle pulse: down-count hit lower bound
- `ovf_sticky`  out  CHANNELS  sticky overflow flag
- `unf_sticky`  out  CHANNELS  sticky underflow flag
- `at_limit`  out  CHANNELS  combinational: `count[i] >= limit[i]`

## Operation
- Channels fully independent; description below is per channel i.
- Priority per cycle: reset > load > en > hold.
- Load: `count <= min(load_val, limit)`; `ovf`/`unf` = 0 that cycle; load ignores `en`, `dir_up`.
- Up, `en`=1, `count < limit`: `count <= count + 1`.
- Up, `en`=1, `count >= limit` (includes limit lowered below current count): wrap mode `count <= 0`; saturate mode `count <= limit`; `ovf` pulses in both modes.
- Down, `en`=1, `count > limit`: `count <= limit` (re-clamp), no event.
- Down, `en`=1, `0 < count <= limit`: `count <= count - 1`.
- Down, `en`=1, `count == 0`: wrap mode `count <= limit`; saturate mode `count <= 0`; `unf` pulses in both modes.
- `limit == 0`: every enabled step is a boundary event; count stays 0 in both modes.
- `limit == all-ones`: natural modulo-2^WIDTH counter; no arithmetic wider than WIDTH+1 bits needed.
- Sticky: `ovf_sticky <= (ovf_sticky & ~clr_sticky) | ovf_next`; same for `unf_sticky`. Event on same cycle as clear: set wins.
- `en`=0, `load`=0: count and stickies hold; `ovf`/`unf` = 0.

## Timing
- Reset (`reset_n`=0 at rising edge): `count`=0, `ovf`=`unf`=0, `ovf_sticky`=`unf_sticky`=0, all channels. Reset mid-count discards state on that edge; no events generated.
- `count`, `ovf`, `unf` update on the same edge; event pulse visible in the cycle the new (wrapped/saturated) value is visible.
- Sticky bits visible the same cycle as the corresponding pulse.
- `at_limit` combinational from registered `count` and input `limit`; no register latency.
- Inputs sampled on rising edge; one-cycle latency from `en`/`load` to `count`.
- Continuous `en` in saturate mode at bound: `ovf` (or `unf`) asserted every cycle.

## Test plan
- Reset: WIDTH=4, CHANNELS=2, drive random inputs, pulse `reset_n`=0 one cycle -> all `count`=0, all flags 0 next cycle.
- Wrap up: ch0 `limit`=5, up, wrap, `en`=1 for 8 cycles -> count 1,2,3,4,5,0,1,2; `ovf` high only with the 5->0 transition; `ovf_sticky` stays 1 until `clr_sticky`.
- Saturate down: ch1 load 2, `limit`=9, down, saturate, `en`=1 4 cycles -> 1,0,0,0; `unf` high on the two cycles showing 0 after 0; ch0 unaffected.
- Load priority/clamp: `load`=1, `en`=1, `load_val`=12, `limit`=7 -> count=7, no `ovf`/`unf`; next up-step with wrap -> 0 with `ovf`.
- Limit change: count=10, lower `limit` to 4, up wrap -> 0 with `ovf`; repeat down -> 4, no event; `at_limit` =1 while count≥4.
- Sticky race: `ovf` event and `clr_sticky` same cycle -> `ovf_sticky`=1; `clr_sticky` next cycle with no event -> 0.
